// File: rtl/coco_muldiv.sv
// Iterative 32-bit multiply/divide unit that owns the HI/LO registers and answers the MulDiv handshake.
// Optional COCO_MULDIV_FAST_MUL_EN: multiply uses a single-cycle product and skips the iterative phase.
module coco_muldiv (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start_i,
   input  logic        MorD_i,
   input  logic        Sign_i,
   input  logic        HorL_i,
   input  logic        We_i,
   input  logic [31:0] A_i,
   input  logic [31:0] B_i,
   output logic [31:0] Result_o,
   output logic        Ready_o,
   output logic        Busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        start_q;
   logic        mord_q, mord_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic        bzero_q, bzero_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] araw_q, araw_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [31:0] a_abs, b_abs;
   logic        start_rise;
   logic [32:0] mul_sum;
   logic [32:0] rem_shift;
   logic [32:0] div_diff;
   logic [63:0] mul_step, div_step;
   logic [63:0] prod_fix;

   // Controller encoding: Sign=1 means unsigned, so magnitudes are only taken for signed ops.
   assign a_abs      = (!Sign_i && A_i[31]) ? (32'd0 - A_i) : A_i;
   assign b_abs      = (!Sign_i && B_i[31]) ? (32'd0 - B_i) : B_i;
   assign start_rise = Start_i & ~start_q;

   // Shift-add: multiplier sits in the low half and is consumed LSB first.
   assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
   assign mul_step = {mul_sum, acc_q[31:1]};

   // Restoring divide: remainder in the high half, dividend shifts out of the low half as quotient shifts in.
   assign rem_shift = acc_q[63:31];
   assign div_diff  = rem_shift - {1'b0, b_q};
   assign div_step  = div_diff[32] ? {rem_shift[31:0], acc_q[30:0], 1'b0}
                                   : {div_diff[31:0], acc_q[30:0], 1'b1};

   assign prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;

   assign Result_o = HorL_i ? hi_q : lo_q;
   assign Busy_o   = (state_q == S_RUN) || (state_q == S_FIX);
   assign Ready_o  = (state_q == S_DONE);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         start_q   <= 1'b0;
         mord_q    <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         bzero_q   <= 1'b0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         araw_q    <= 32'd0;
         acc_q     <= 64'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         start_q   <= Start_i;
         mord_q    <= mord_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         bzero_q   <= bzero_d;
         a_q       <= a_d;
         b_q       <= b_d;
         araw_q    <= araw_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mord_d    = mord_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      bzero_d   = bzero_q;
      a_d       = a_q;
      b_d       = b_q;
      araw_d    = araw_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         S_IDLE: begin
            if (We_i) begin
               if (HorL_i) hi_d = A_i;
               else        lo_d = A_i;
            end
            if (start_rise) begin
               mord_d    = MorD_i;
               neg_res_d = !Sign_i && (A_i[31] ^ B_i[31]);
               neg_rem_d = !Sign_i && A_i[31];
               bzero_d   = (B_i == 32'd0);
               a_d       = a_abs;
               b_d       = b_abs;
               araw_d    = A_i;
               cnt_d     = 5'd0;
               acc_d     = MorD_i ? {32'd0, b_abs} : {32'd0, a_abs};
               state_d   = S_RUN;
`ifdef COCO_MULDIV_FAST_MUL_EN
               if (MorD_i) begin
                  acc_d   = {32'd0, a_abs} * {32'd0, b_abs};
                  state_d = S_FIX;
               end
`endif
            end
         end
         S_RUN: begin
            acc_d = mord_q ? mul_step : div_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = S_FIX;
         end
         S_FIX: begin
            if (mord_q) begin
               {hi_d, lo_d} = prod_fix;
            end else if (bzero_q) begin
               lo_d = 32'hFFFF_FFFF;
               hi_d = araw_q;
            end else begin
               lo_d = neg_res_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
               hi_d = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (We_i) begin
               if (HorL_i) hi_d = A_i;
               else        lo_d = A_i;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_coco_muldiv.sv
// Self-checking bench for coco_muldiv: vector table, random model ops and hand-written corner sequences.
module tb_coco_muldiv;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start_i = 1'b0;
   logic        MorD_i = 1'b0;
   logic        Sign_i = 1'b0;
   logic        HorL_i = 1'b0;
   logic        We_i = 1'b0;
   logic [31:0] A_i = 32'd0;
   logic [31:0] B_i = 32'd0;
   logic [31:0] Result_o;
   logic        Ready_o;
   logic        Busy_o;

   int n_total = 0;
   int n_pass  = 0;
   logic [63:0] sb_q[$];

   coco_muldiv dut (
      .Clk(Clk), .Reset(Reset), .Start_i(Start_i), .MorD_i(MorD_i), .Sign_i(Sign_i),
      .HorL_i(HorL_i), .We_i(We_i), .A_i(A_i), .B_i(B_i),
      .Result_o(Result_o), .Ready_o(Ready_o), .Busy_o(Busy_o)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      string       name;
      logic        mord;
      logic        sign;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int exp_lat(input logic mord);
`ifdef COCO_MULDIV_FAST_MUL_EN
      return mord ? 2 : 34;
`else
      return 34;
`endif
   endfunction

   // Reference behaviour from native SV arithmetic, with the two architected special cases.
   function automatic logic [63:0] model(input logic mord, input logic sign,
                                         input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      int sa, sbv;
      if (mord) begin
         if (sign) return {32'd0, a} * {32'd0, b};
         sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         return sp;
      end
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sign) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa  = a;
      sbv = b;
      return {32'(sa % sbv), 32'(sa / sbv)};
   endfunction

   task automatic launch(input logic mord, input logic sign, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
      @(negedge Clk);
      MorD_i  = mord;
      Sign_i  = sign;
      A_i     = a;
      B_i     = b;
      Start_i = 1'b1;
      sb_q.push_back(exp);
   endtask

   // Waits for Ready; optionally pulses We while busy; holds Start after Ready to prove no relaunch.
   task automatic wait_ready(input string name, input int lat, input int hold, input int we_cyc,
                             input logic [31:0] old_hi, input logic [31:0] old_lo);
      int cyc;
      logic [63:0] exp;
      logic [31:0] hi, lo;
      logic extra;
      cyc = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge Clk);
         if (i == 1) chk({name, "_busy"}, {63'd0, Busy_o}, 64'd1);
         if (we_cyc != 0 && i == we_cyc) begin
            We_i = 1'b1; HorL_i = 1'b1; A_i = 32'hDEAD_BEEF;
         end
         if (we_cyc != 0 && i == we_cyc + 1) begin
            We_i = 1'b0;
            HorL_i = 1'b1; #1;
            chk({name, "_busy_hi"}, {32'd0, Result_o}, {32'd0, old_hi});
            HorL_i = 1'b0; #1;
            chk({name, "_busy_lo"}, {32'd0, Result_o}, {32'd0, old_lo});
         end
         if (Ready_o) begin
            cyc = i;
            break;
         end
      end
      if (cyc == 0) begin
         n_total++;
         $display("FAIL %s_timeout: got no Ready within 100 cycles, expected cycle %0d", name, lat);
         Start_i = 1'b0;
         if (sb_q.size() > 0) void'(sb_q.pop_front());
         return;
      end
      chk({name, "_latency"}, 64'(cyc), 64'(lat));
      HorL_i = 1'b1; #1; hi = Result_o;
      HorL_i = 1'b0; #1; lo = Result_o;
      if (sb_q.size() == 0) begin
         n_total++;
         $display("FAIL %s_sb: got Ready, expected empty scoreboard", name);
      end else begin
         exp = sb_q.pop_front();
         chk({name, "_hilo"}, {hi, lo}, exp);
      end
      extra = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge Clk);
         extra = extra | Ready_o | Busy_o;
      end
      chk({name, "_no_relaunch"}, {63'd0, extra}, 64'd0);
      Start_i = 1'b0;
      $display("op %-14s hi=0x%08h lo=0x%08h lat=%0d", name, hi, lo, cyc);
   endtask

   vec_t vecs[10];

   initial begin
      logic [31:0] ra, rb;
      logic rm, rs;
      logic rdy_seen;

      vecs[0] = '{"mult_m2x3",    1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[1] = '{"multu_max",    1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{"div_m7d2",     1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{"divu_7d0",     1'b0, 1'b1, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
      vecs[4] = '{"div_ovf",      1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
      vecs[5] = '{"div_m7d0",     1'b0, 1'b0, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[6] = '{"multu_2p32",   1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};
      vecs[7] = '{"divu_100d7",   1'b0, 1'b1, 32'd100,       32'd7,         32'd2,         32'd14};
      vecs[8] = '{"div_7dm2",     1'b0, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[9] = '{"mult_minsq",   1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};

      // Reset state
      repeat (2) @(negedge Clk);
      HorL_i = 1'b1; #1;
      chk("reset_hi", {32'd0, Result_o}, 64'd0);
      HorL_i = 1'b0; #1;
      chk("reset_lo", {32'd0, Result_o}, 64'd0);
      chk("reset_ready_busy", {62'd0, Ready_o, Busy_o}, 64'd0);
      @(negedge Clk);
      Reset = 1'b0;

      foreach (vecs[i]) begin
         launch(vecs[i].mord, vecs[i].sign, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
         wait_ready(vecs[i].name, exp_lat(vecs[i].mord), (i == 1) ? 5 : 2, 0, 32'd0, 32'd0);
      end

      for (int k = 0; k < 8; k++) begin
         ra = $urandom;
         rb = (k == 3) ? 32'd0 : $urandom;
         rm = k[0];
         rs = k[1];
         launch(rm, rs, ra, rb, model(rm, rs, ra, rb));
         wait_ready($sformatf("rand%0d", k), exp_lat(rm), 1, 0, 32'd0, 32'd0);
      end

      // MTHI / MTLO then read back
      @(negedge Clk);
      We_i = 1'b1; HorL_i = 1'b1; A_i = 32'h1234_5678;
      @(negedge Clk);
      We_i = 1'b0; #1;
      chk("mthi_mfhi", {32'd0, Result_o}, 64'h1234_5678);
      We_i = 1'b1; HorL_i = 1'b0; A_i = 32'hCAFE_BABE;
      @(negedge Clk);
      We_i = 1'b0; #1;
      chk("mtlo_mflo", {32'd0, Result_o}, 64'hCAFE_BABE);
      HorL_i = 1'b1; #1;
      chk("mtlo_hi_kept", {32'd0, Result_o}, 64'h1234_5678);
      $display("op %-14s hi=0x12345678 lo=0xcafebabe", "mthi_mtlo");

      // We while busy is ignored; old HI/LO remain readable until commit
      launch(1'b0, 1'b1, 32'd100, 32'd7, {32'd2, 32'd14});
      wait_ready("busy_we", 34, 1, 5, 32'h1234_5678, 32'hCAFE_BABE);

      // Reset during a divide
      launch(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      repeat (10) @(negedge Clk);
      Reset = 1'b1;
      Start_i = 1'b0;
      void'(sb_q.pop_front());
      #1;
      chk("rst_mid_busy", {63'd0, Busy_o}, 64'd0);
      HorL_i = 1'b1; #1;
      chk("rst_mid_hi", {32'd0, Result_o}, 64'd0);
      HorL_i = 1'b0; #1;
      chk("rst_mid_lo", {32'd0, Result_o}, 64'd0);
      @(negedge Clk);
      Reset = 1'b0;
      rdy_seen = 1'b0;
      repeat (40) begin
         @(negedge Clk);
         rdy_seen = rdy_seen | Ready_o;
      end
      chk("rst_mid_no_ready", {63'd0, rdy_seen}, 64'd0);
      $display("op %-14s aborted", "rst_mid_div");
      launch(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      wait_ready("after_rst", 34, 1, 0, 32'd0, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got simulation still running, expected completion");
      $fatal(1);
   end

endmodule
